// File: rtl/rv32_instr_encoder.sv
// rtl/rv32_instr_encoder.sv - RV32I field-descriptor to instruction-word encoder with address-tagged output FIFO
module rv32_instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_class,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [2:0]                 in_funct3,
    input  logic                       in_func7,
    input  logic [31:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_addr  [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_ctr;
    logic          err_q;
    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept, push, pop;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_class)
            4'd0: enc_word = {1'b0, in_func7, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            4'd1: begin
                // shifts carry shamt plus the SRAI/SRLI select bit instead of a 12-bit immediate
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {1'b0, in_func7, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            end
            4'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            4'd3: enc_word = {in_imm[31:12], in_rd, OP_LUI};
            4'd4: enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
            4'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            4'd6: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], OP_BRANCH};
            4'd7: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            4'd8: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready  = !rst && (cnt < DEPTH_C);
    assign out_valid = (cnt != '0);
    assign out_instr = out_valid ? mem_instr[rptr] : '0;
    assign out_addr  = out_valid ? mem_addr[rptr]  : '0;
    assign count     = cnt;
    assign err       = err_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            addr_ctr <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wptr     <= wptr + AW'(1);
                addr_ctr <= addr_ctr + 32'd4;
            end
            if (pop)
                rptr <= rptr + AW'(1);
            if (accept && !enc_legal)
                err_q <= 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // storage needs no reset: entries are only visible through cnt
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wptr] <= enc_word;
            mem_addr[wptr]  <= addr_ctr;
        end
    end
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb/tb_rv32_instr_encoder.sv - directed table-driven bench for rv32_instr_encoder
module tb_rv32_instr_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_func7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [2:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_func7(in_func7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .err(err)
    );

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t addi(input int k);
        vec_t v;
        v = '{4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(k), 32'((k << 20) | 32'h93)};
        return v;
    endfunction

    task automatic push(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        in_class  = v.cls;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_func7  = v.f7;
        in_imm    = v.imm;
        in_valid  = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] got_i [$];
        logic [31:0] got_a [$];
        logic        acc;
        vec_t        v;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_func7 = 1'b0; in_imm = '0;

        tbl[0]  = '{4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0,        32'h002081B3};
        tbl[1]  = '{4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'h0,        32'h402081B3};
        tbl[2]  = '{4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFF00093};
        tbl[3]  = '{4'd2, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8,        32'h0020A423};
        tbl[4]  = '{4'd3, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 32'h123452B7};
        tbl[5]  = '{4'd6, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC, 32'hFE208EE3};
        tbl[6]  = '{4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,        32'h008000EF};
        tbl[7]  = '{4'd8, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd16,       32'h01012283};
        tbl[8]  = '{4'd7, 5'd0, 5'd1, 5'd0, 3'd3, 1'b0, 32'h0,        32'h00008067};
        tbl[9]  = '{4'd1, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'hFFFFFFE3, 32'h4030D093};
        tbl[10] = '{4'd4, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE123, 32'hABCDE117};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // encoding table: one word at a time, address advances by 4 per legal word
        for (int i = 0; i < 11; i++) begin
            push(tbl[i]);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].exp);
            chk($sformatf("vec%0d_addr", i), out_addr, 32'(4 * i));
            pop_one();
        end
        chk("table_drained_count", 32'(count), 32'd0);

        // backpressure: fill, hold the fifth, then drain
        do_reset();
        for (int k = 1; k <= 4; k++) push(addi(k));
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        v = addi(5);
        @(negedge clk);
        in_class = v.cls; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_func7 = v.f7; in_imm = v.imm; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("held_count", 32'(count), 32'd4);
        chk("held_head_addr", out_addr, 32'h0);
        got_i.delete(); got_a.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got_i.size() < 5; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                got_i.push_back(out_instr);
                got_a.push_back(out_addr);
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("bp_word_count", 32'(got_i.size()), 32'd5);
        for (int k = 0; k < 5 && k < got_i.size(); k++) begin
            v = addi(k + 1);
            chk($sformatf("bp%0d_instr", k), got_i[k], v.exp);
            chk($sformatf("bp%0d_addr", k), got_a[k], 32'(4 * k));
        end

        // illegal class between two legal descriptors
        do_reset();
        push(addi(1));
        chk("pre_illegal_err", 32'(err), 32'd0);
        v = addi(0);
        v.cls = 4'hF;
        push(v);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_count", 32'(count), 32'd1);
        push(addi(2));
        chk("illegal_total_count", 32'(count), 32'd2);
        chk("illegal_w0_addr", out_addr, 32'h0);
        chk("illegal_w0_instr", out_instr, addi(1).exp);
        pop_one();
        chk("illegal_w1_addr", out_addr, 32'h4);
        chk("illegal_w1_instr", out_instr, addi(2).exp);
        pop_one();
        chk("illegal_empty_valid", 32'(out_valid), 32'd0);
        chk("illegal_err_sticky", 32'(err), 32'd1);

        // reset mid-operation with 3 queued words
        for (int k = 1; k <= 3; k++) push(addi(k));
        chk("mid_count", 32'(count), 32'd3);
        do_reset();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        push(addi(7));
        chk("mid_next_addr", out_addr, 32'h0);
        chk("mid_next_instr", out_instr, addi(7).exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $fatal(1, "timeout");
    end
endmodule
